// File: rtl/systolic_array_load_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : systolic_array_pkg
// Description : Shared types and constants for the systolic-array tile loader.
// Revision    : 1.0 - initial release
// ============================================================================
package systolic_array_pkg;

    localparam int c_array_dim = 4;
    localparam int c_mul_len   = 3;
    localparam int c_add_len   = 2;
    // Skew in + skew out + pipeline fill, plus MAC multiply and add latency.
    localparam int c_drain_len = 3 * c_array_dim + c_mul_len + c_add_len;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_W = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } load_sched_state_t;

endpackage
`default_nettype wire

// File: rtl/systolic_array_load_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : systolic_array_load_scheduler_if
// Description : Memory-side load channels and control-unit load bus.
// Revision    : 1.0 - initial release
// ============================================================================
interface systolic_array_load_scheduler_if #(
    parameter int array_dim = 4,
    parameter int data_w    = 16
);
    localparam int c_row_w = $clog2(array_dim);
    localparam int c_bus_w = array_dim * data_w;

    logic               w_req,  i_req,  p_req;
    logic [c_row_w-1:0] w_row,  i_row,  p_row;
    logic [c_bus_w-1:0] w_data, i_data, p_data;
    logic               w_gnt,  i_gnt,  p_gnt;
    logic               fifo_has_space;
    logic               weight_en, input_en, partial_en;
    logic [c_row_w-1:0] row_in_en, row_ps_en;
    logic [c_bus_w-1:0] load_data;

    // master: the scheduler; slave: fetch logic plus control unit
    modport master (
        input  w_req, i_req, p_req, w_row, i_row, p_row,
        input  w_data, i_data, p_data, fifo_has_space,
        output w_gnt, i_gnt, p_gnt,
        output weight_en, input_en, partial_en, row_in_en, row_ps_en, load_data
    );

    modport slave (
        output w_req, i_req, p_req, w_row, i_row, p_row,
        output w_data, i_data, p_data, fifo_has_space,
        input  w_gnt, i_gnt, p_gnt,
        input  weight_en, input_en, partial_en, row_in_en, row_ps_en, load_data
    );

endinterface
`default_nettype wire

// File: rtl/systolic_array_load_scheduler_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : systolic_rr_arb2
// Description : Two-way round-robin arbiter, favours requester 0 after reset.
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic r_last;   // 1 when requester 1 won most recently

    always_comb begin
        gnt = 2'b00;
        if (req[0] && (!req[1] || r_last)) begin
            gnt = 2'b01;
        end else if (req[1]) begin
            gnt = 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (gnt[0]) begin
            r_last <= 1'b0;
        end else if (gnt[1]) begin
            r_last <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/systolic_array_load_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : systolic_array_load_scheduler
// Description : Sequences one tile (weights, input/partial stream, drain) onto
//               the systolic-array control unit load bus.
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_array_load_scheduler
    import systolic_array_pkg::*;
#(
    parameter int array_dim = c_array_dim,
    parameter int data_w    = 16,
    parameter int drain_len = c_drain_len
) (
    input  logic CLK,
    input  logic RST,
    input  logic start,
    systolic_array_load_scheduler_if.master ld,
    output logic busy,
    output logic tile_done,
    output logic order_err
);

    localparam int c_cnt_w  = $clog2(array_dim + 1);
    localparam int c_dcnt_w = $clog2(drain_len + 1);

    localparam logic [c_cnt_w-1:0]  c_last      = c_cnt_w'(array_dim - 1);
    localparam logic [c_cnt_w-1:0]  c_full      = c_cnt_w'(array_dim);
    localparam logic [c_dcnt_w-1:0] c_dcnt_puls = c_dcnt_w'(drain_len - 2);
    localparam logic [c_dcnt_w-1:0] c_dcnt_last = c_dcnt_w'(drain_len - 1);

    load_sched_state_t    r_state;
    logic [c_cnt_w-1:0]   r_wcnt, r_icnt, r_pcnt;
    logic [c_dcnt_w-1:0]  r_dcnt;
    logic                 r_tile_done, r_order_err;

    logic w_in_load, w_in_stream, w_start_ok;
    logic w_wrow_ok, w_irow_ok, w_prow_ok;
    logic w_i_live, w_p_live, w_i_elig, w_p_elig;
    logic w_order_bad, w_stream_done;
    logic [1:0] w_arb_gnt;

    assign w_in_load   = (r_state == LOAD_W);
    assign w_in_stream = (r_state == STREAM);
    assign w_start_ok  = (r_state == IDLE) && start;

    assign w_wrow_ok = (c_cnt_w'(ld.w_row) == r_wcnt);
    assign w_irow_ok = (c_cnt_w'(ld.i_row) == r_icnt);
    assign w_prow_ok = (c_cnt_w'(ld.p_row) == r_pcnt);

    // A saturated channel is no longer live: it is neither granted nor flagged.
    assign w_i_live = ld.i_req && (r_icnt < c_full);
    assign w_p_live = ld.p_req && (r_pcnt < c_full);
    assign w_i_elig = w_in_stream && w_i_live && w_irow_ok && ld.fifo_has_space && !RST;
    assign w_p_elig = w_in_stream && w_p_live && w_prow_ok && ld.fifo_has_space && !RST;

    assign w_order_bad = (w_in_load && ld.w_req && !w_wrow_ok) ||
                         (w_in_stream && ((w_i_live && !w_irow_ok) || (w_p_live && !w_prow_ok)));

    systolic_rr_arb2 u_arb (
        .clk (CLK),
        .rst (RST || w_start_ok),
        .req ({w_p_elig, w_i_elig}),
        .gnt (w_arb_gnt)
    );

    // Weights bypass the FIFOs, so fifo_has_space does not gate them.
    assign ld.w_gnt = w_in_load && ld.w_req && w_wrow_ok && !RST;
    assign ld.i_gnt = w_arb_gnt[0];
    assign ld.p_gnt = w_arb_gnt[1];

    assign w_stream_done = (ld.i_gnt && (r_icnt == c_last) && (r_pcnt == c_full)) ||
                           (ld.p_gnt && (r_pcnt == c_last) && (r_icnt == c_full));

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state       <= IDLE;
            r_wcnt        <= '0;
            r_icnt        <= '0;
            r_pcnt        <= '0;
            r_dcnt        <= '0;
            r_tile_done   <= 1'b0;
            r_order_err   <= 1'b0;
            ld.weight_en  <= 1'b0;
            ld.input_en   <= 1'b0;
            ld.partial_en <= 1'b0;
            ld.row_in_en  <= '0;
            ld.row_ps_en  <= '0;
            ld.load_data  <= '0;
        end else begin
            ld.weight_en  <= 1'b0;
            ld.input_en   <= 1'b0;
            ld.partial_en <= 1'b0;
            r_tile_done   <= 1'b0;
            if (w_order_bad) begin
                r_order_err <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state     <= LOAD_W;
                        r_wcnt      <= '0;
                        r_icnt      <= '0;
                        r_pcnt      <= '0;
                        r_dcnt      <= '0;
                        r_order_err <= 1'b0;
                    end
                end
                LOAD_W: begin
                    if (ld.w_gnt) begin
                        ld.weight_en <= 1'b1;
                        ld.row_in_en <= ld.w_row;
                        ld.load_data <= ld.w_data;
                        r_wcnt       <= r_wcnt + c_cnt_w'(1);
                        if (r_wcnt == c_last) begin
                            r_state <= STREAM;
                        end
                    end
                end
                STREAM: begin
                    if (ld.i_gnt) begin
                        ld.input_en  <= 1'b1;
                        ld.row_in_en <= ld.i_row;
                        ld.load_data <= ld.i_data;
                        r_icnt       <= r_icnt + c_cnt_w'(1);
                    end
                    if (ld.p_gnt) begin
                        ld.partial_en <= 1'b1;
                        ld.row_ps_en  <= ld.p_row;
                        ld.load_data  <= ld.p_data;
                        r_pcnt        <= r_pcnt + c_cnt_w'(1);
                    end
                    if (w_stream_done) begin
                        r_state <= DRAIN;
                        r_dcnt  <= '0;
                    end
                end
                DRAIN: begin
                    r_dcnt <= r_dcnt + c_dcnt_w'(1);
                    // Registered pulse lands on the final DRAIN cycle.
                    if (r_dcnt == c_dcnt_puls) begin
                        r_tile_done <= 1'b1;
                    end
                    if (r_dcnt == c_dcnt_last) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy      = (r_state != IDLE);
    assign tile_done = r_tile_done;
    assign order_err = r_order_err;

endmodule
`default_nettype wire

// File: tb/tb_systolic_array_load_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_systolic_array_load_scheduler
// Description : Scoreboard bench for the systolic-array tile load scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_array_load_scheduler;

    localparam int c_dim   = 4;
    localparam int c_dw    = 16;
    localparam int c_drain = 17;

    typedef struct {
        int          kind;   // 0 weight, 1 input, 2 partial
        logic [1:0]  row;
        logic [63:0] data;
        int          due;
    } sb_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic start = 1'b0;
    logic busy, tile_done, order_err;

    systolic_array_load_scheduler_if #(.array_dim(c_dim), .data_w(c_dw)) ld ();

    systolic_array_load_scheduler #(
        .array_dim (c_dim),
        .data_w    (c_dw),
        .drain_len (c_drain)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start),
        .ld        (ld),
        .busy      (busy),
        .tile_done (tile_done),
        .order_err (order_err)
    );

    always #5 CLK = ~CLK;

    sb_t sb[$];
    sb_t mon_e;
    logic [2:0] mon_en_exp;
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    bit  mon_en = 1'b0;

    int  m_icnt, m_pcnt, m_last_gnt;
    bit  m_last_p;

    always @(posedge CLK) cyc <= cyc + 1;

    // Bus monitor: every expected row appears exactly one cycle after its grant.
    always @(negedge CLK) begin
        if (mon_en) begin
            while (sb.size() > 0 && sb[0].due < cyc) begin
                checks++;
                errors++;
                $display("FAIL sb_missed kind=%0d due=%0d now=%0d", sb[0].kind, sb[0].due, cyc);
                sb.delete(0);
            end
            checks++;
            if (sb.size() > 0 && sb[0].due == cyc) begin
                mon_e = sb.pop_front();
                mon_en_exp = (mon_e.kind == 0) ? 3'b100 : (mon_e.kind == 1) ? 3'b010 : 3'b001;
                if ({ld.weight_en, ld.input_en, ld.partial_en} !== mon_en_exp ||
                    ld.load_data !== mon_e.data ||
                    (mon_e.kind != 2 && ld.row_in_en !== mon_e.row) ||
                    (mon_e.kind == 2 && ld.row_ps_en !== mon_e.row)) begin
                    errors++;
                    $display("FAIL bus_out cyc=%0d en=%b exp_en=%b row_in=%0d row_ps=%0d exp_row=%0d data=%h exp_data=%h",
                             cyc, {ld.weight_en, ld.input_en, ld.partial_en}, mon_en_exp,
                             ld.row_in_en, ld.row_ps_en, mon_e.row, ld.load_data, mon_e.data);
                end
            end else if ({ld.weight_en, ld.input_en, ld.partial_en} !== 3'b000) begin
                errors++;
                $display("FAIL bus_idle cyc=%0d en=%b exp_en=000", cyc,
                         {ld.weight_en, ld.input_en, ld.partial_en});
            end
        end
    end

    task automatic tick;
        @(posedge CLK);
        #2;
    endtask

    task automatic idle_inputs;
        start = 1'b0;
        ld.w_req = 1'b0; ld.i_req = 1'b0; ld.p_req = 1'b0;
        ld.w_row = '0;   ld.i_row = '0;   ld.p_row = '0;
        ld.w_data = '0;  ld.i_data = '0;  ld.p_data = '0;
        ld.fifo_has_space = 1'b1;
    endtask

    task automatic push(input int kind, input logic [1:0] row, input logic [63:0] data);
        sb_t e;
        e.kind = kind; e.row = row; e.data = data; e.due = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic test_reset;
        idle_inputs();
        RST = 1'b1;
        ld.w_req = 1'b1; ld.i_req = 1'b1; ld.p_req = 1'b1;
        tick();
        mon_en = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || tile_done !== 1'b0 || order_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_status busy=%b done=%b err=%b exp=000", busy, tile_done, order_err);
        end
        checks++;
        if (ld.row_in_en !== 2'd0 || ld.row_ps_en !== 2'd0 || ld.load_data !== 64'd0) begin
            errors++;
            $display("FAIL reset_bus row_in=%0d row_ps=%0d data=%h exp=0", ld.row_in_en, ld.row_ps_en, ld.load_data);
        end
        checks++;
        if ({ld.w_gnt, ld.i_gnt, ld.p_gnt} !== 3'b000) begin
            errors++;
            $display("FAIL reset_gnt gnt=%b exp=000", {ld.w_gnt, ld.i_gnt, ld.p_gnt});
        end
        RST = 1'b0;
        tick();
        checks++;
        if ({ld.w_gnt, ld.i_gnt, ld.p_gnt} !== 3'b000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset gnt=%b busy=%b exp=000/0", {ld.w_gnt, ld.i_gnt, ld.p_gnt}, busy);
        end
        idle_inputs();
    endtask

    task automatic start_tile;
        tick();
        idle_inputs();
        start = 1'b1;
        tick();
        start = 1'b0;
        m_icnt = 0; m_pcnt = 0; m_last_p = 1'b1;
        checks++;
        if (busy !== 1'b1 || order_err !== 1'b0) begin
            errors++;
            $display("FAIL start_accept busy=%b err=%b exp=1/0", busy, order_err);
        end
    endtask

    task automatic load_weights;
        logic [63:0] d;
        for (int r = 0; r < c_dim; r++) begin
            tick();
            d = {$urandom(), $urandom()};
            ld.w_req = 1'b1; ld.w_row = 2'(r); ld.w_data = d;
            ld.i_req = 1'b1; ld.p_req = 1'b1; ld.i_row = '0; ld.p_row = '0;
            ld.fifo_has_space = 1'b1;
            #2;
            checks++;
            if ({ld.w_gnt, ld.i_gnt, ld.p_gnt} !== 3'b100) begin
                errors++;
                $display("FAIL load_w_gnt row=%0d gnt=%b exp=100", r, {ld.w_gnt, ld.i_gnt, ld.p_gnt});
            end
            push(0, 2'(r), d);
        end
    endtask

    task automatic stream_cycles(input int n, input bit ir, input bit pr, input bit fs, input bit st);
        bit ie, pe, ei, ep;
        logic [63:0] di, dp;
        for (int k = 0; k < n; k++) begin
            tick();
            di = {$urandom(), $urandom()};
            dp = {$urandom(), $urandom()};
            start = st;
            ld.w_req = 1'b0;
            ld.i_req = ir; ld.i_row = (m_icnt < c_dim) ? 2'(m_icnt) : 2'd0; ld.i_data = di;
            ld.p_req = pr; ld.p_row = (m_pcnt < c_dim) ? 2'(m_pcnt) : 2'd0; ld.p_data = dp;
            ld.fifo_has_space = fs;
            #2;
            ie = ir && (m_icnt < c_dim) && fs;
            pe = pr && (m_pcnt < c_dim) && fs;
            ei = ie && (!pe || m_last_p);
            ep = pe && (!ie || !m_last_p);
            checks++;
            if (ld.i_gnt !== ei || ld.p_gnt !== ep || ld.w_gnt !== 1'b0) begin
                errors++;
                $display("FAIL stream_gnt cyc=%0d i=%b p=%b w=%b exp_i=%b exp_p=%b", cyc,
                         ld.i_gnt, ld.p_gnt, ld.w_gnt, ei, ep);
            end
            if (ei) begin
                push(1, 2'(m_icnt), di);
                m_icnt++; m_last_p = 1'b0; m_last_gnt = cyc;
            end
            if (ep) begin
                push(2, 2'(m_pcnt), dp);
                m_pcnt++; m_last_p = 1'b1; m_last_gnt = cyc;
            end
        end
        start = 1'b0;
    endtask

    task automatic wait_drain(input bit poke);
        int seen_at;
        seen_at = -1;
        for (int k = 0; k < 40 && seen_at < 0; k++) begin
            tick();
            start = poke && (k == 3);
            ld.w_req = 1'b1; ld.i_req = 1'b1; ld.p_req = 1'b1;
            ld.w_row = '0; ld.i_row = '0; ld.p_row = '0;
            ld.fifo_has_space = 1'b1;
            #2;
            checks++;
            if ({ld.w_gnt, ld.i_gnt, ld.p_gnt} !== 3'b000) begin
                errors++;
                $display("FAIL drain_gnt cyc=%0d gnt=%b exp=000", cyc, {ld.w_gnt, ld.i_gnt, ld.p_gnt});
            end
            if (tile_done === 1'b1) begin
                seen_at = cyc;
            end else begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL drain_busy cyc=%0d busy=%b exp=1", cyc, busy);
                end
            end
        end
        start = 1'b0;
        checks++;
        if (seen_at != m_last_gnt + c_drain) begin
            errors++;
            $display("FAIL tile_done_time at=%0d exp=%0d", seen_at, m_last_gnt + c_drain);
        end
        tick();
        checks++;
        if (tile_done !== 1'b0 || busy !== 1'b0 || {ld.w_gnt, ld.i_gnt, ld.p_gnt} !== 3'b000) begin
            errors++;
            $display("FAIL tile_end done=%b busy=%b gnt=%b exp=0/0/000", tile_done, busy,
                     {ld.w_gnt, ld.i_gnt, ld.p_gnt});
        end
        idle_inputs();
    endtask

    task automatic test_order_err;
        start_tile();
        tick();
        ld.w_req = 1'b1; ld.w_row = 2'd2;
        #2;
        checks++;
        if (ld.w_gnt !== 1'b0) begin
            errors++;
            $display("FAIL wrong_row_gnt gnt=%b exp=0", ld.w_gnt);
        end
        tick();
        checks++;
        if (order_err !== 1'b1) begin
            errors++;
            $display("FAIL order_err_set err=%b exp=1", order_err);
        end
        ld.w_req = 1'b0;
        tick();
        checks++;
        if (order_err !== 1'b1) begin
            errors++;
            $display("FAIL order_err_sticky err=%b exp=1", order_err);
        end
        load_weights();
        tick();
        ld.w_req = 1'b0; ld.i_req = 1'b0; ld.p_req = 1'b0;
        checks++;
        if (order_err !== 1'b1) begin
            errors++;
            $display("FAIL order_err_hold err=%b exp=1", order_err);
        end
        m_last_gnt = cyc;
    endtask

    task automatic test_reset_mid;
        stream_cycles(2, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        RST = 1'b1;
        ld.i_req = 1'b1; ld.i_row = 2'd2; ld.p_req = 1'b1; ld.p_row = 2'd0;
        #2;
        checks++;
        if ({ld.w_gnt, ld.i_gnt, ld.p_gnt} !== 3'b000) begin
            errors++;
            $display("FAIL reset_cycle_gnt gnt=%b exp=000", {ld.w_gnt, ld.i_gnt, ld.p_gnt});
        end
        tick();
        RST = 1'b0;
        #2;
        checks++;
        if (busy !== 1'b0 || order_err !== 1'b0 ||
            {ld.weight_en, ld.input_en, ld.partial_en, ld.w_gnt, ld.i_gnt, ld.p_gnt} !== 6'd0) begin
            errors++;
            $display("FAIL mid_reset busy=%b err=%b en=%b gnt=%b exp=0/0/000/000", busy, order_err,
                     {ld.weight_en, ld.input_en, ld.partial_en}, {ld.w_gnt, ld.i_gnt, ld.p_gnt});
        end
        idle_inputs();
    endtask

    task automatic test_restart_stall;
        start_tile();
        tick();
        ld.w_req = 1'b1; ld.w_row = 2'd1;
        #2;
        checks++;
        if (ld.w_gnt !== 1'b0) begin
            errors++;
            $display("FAIL restart_row0_first gnt=%b exp=0", ld.w_gnt);
        end
        load_weights();
        stream_cycles(1, 1'b1, 1'b0, 1'b1, 1'b0);
        stream_cycles(3, 1'b1, 1'b1, 1'b1, 1'b0);
        stream_cycles(3, 1'b1, 1'b1, 1'b0, 1'b0);
        stream_cycles(4, 1'b1, 1'b1, 1'b1, 1'b0);
        wait_drain(1'b0);
    endtask

    task automatic test_back_to_back;
        start_tile();
        load_weights();
        stream_cycles(4, 1'b1, 1'b1, 1'b1, 1'b1);
        stream_cycles(4, 1'b1, 1'b1, 1'b1, 1'b0);
        wait_drain(1'b1);
    endtask

    task automatic test_idle_reqs;
        for (int k = 0; k < 4; k++) begin
            tick();
            ld.w_req = 1'b1; ld.i_req = 1'b1; ld.p_req = 1'b1;
            ld.w_row = '0; ld.i_row = '0; ld.p_row = '0;
            ld.fifo_has_space = 1'b1;
            #2;
            checks++;
            if ({ld.w_gnt, ld.i_gnt, ld.p_gnt} !== 3'b000 || busy !== 1'b0) begin
                errors++;
                $display("FAIL idle_reqs gnt=%b busy=%b exp=000/0", {ld.w_gnt, ld.i_gnt, ld.p_gnt}, busy);
            end
        end
        idle_inputs();
        tick();
        tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover size=%0d exp=0", sb.size());
        end
    endtask

    initial begin
        idle_inputs();
        m_icnt = 0; m_pcnt = 0; m_last_p = 1'b1; m_last_gnt = 0;
        test_reset();
        test_order_err();
        test_reset_mid();
        test_restart_stall();
        test_back_to_back();
        test_idle_reqs();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
